// File: rtl/bit_serializer.sv
// Parallel-to-serial shifter feeding the sequence detector: valid/ready word intake,
// one bit per clock on ser_out, fixed idle level when no word is in flight.
module bit_serializer #(
    parameter int unsigned DATA_W    = 8,
    parameter bit          MSB_FIRST = 1'b1,
    parameter bit          IDLE_BIT  = 1'b0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              s_valid,
    input  logic [DATA_W-1:0] s_data,
    output logic              s_ready,
    output logic              ser_out,
    output logic              ser_valid,
    output logic              word_done,
    output logic              busy
);

    localparam int unsigned      CNT_W    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] PRE_LAST = CNT_W'(DATA_W - 2);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    state_t            r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [DATA_W-1:0] r_shift;
    logic              r_ser_out;
    logic              r_ser_valid;
    logic              r_word_done;

    state_t            w_state_nxt;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic [DATA_W-1:0] w_shift_nxt;
    logic              w_ser_out_nxt;
    logic              w_ser_valid_nxt;
    logic              w_word_done_nxt;
    logic              w_last;
    logic              w_accept;

    // Ready depends only on state, so upstream can never form a loop through s_valid.
    assign w_last   = (r_state == ST_SHIFT) && (r_cnt == LAST_CNT);
    assign s_ready  = (r_state == ST_IDLE) || w_last;
    assign w_accept = s_valid && s_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_shift     <= '0;
            r_ser_out   <= IDLE_BIT;
            r_ser_valid <= 1'b0;
            r_word_done <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_shift     <= w_shift_nxt;
            r_ser_out   <= w_ser_out_nxt;
            r_ser_valid <= w_ser_valid_nxt;
            r_word_done <= w_word_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_shift_nxt     = r_shift;
        w_ser_out_nxt   = IDLE_BIT;
        w_ser_valid_nxt = 1'b0;
        w_word_done_nxt = 1'b0;

        if (w_accept) begin
            // First bit goes straight to the output register; the shifter keeps the rest.
            w_state_nxt     = ST_SHIFT;
            w_cnt_nxt       = '0;
            w_ser_valid_nxt = 1'b1;
            if (MSB_FIRST) begin
                w_ser_out_nxt = s_data[DATA_W-1];
                w_shift_nxt   = s_data << 1;
            end else begin
                w_ser_out_nxt = s_data[0];
                w_shift_nxt   = s_data >> 1;
            end
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_state_nxt = ST_IDLE;
                end
                ST_SHIFT: begin
                    if (w_last) begin
                        w_state_nxt = ST_IDLE;
                        w_cnt_nxt   = '0;
                        w_shift_nxt = '0;
                    end else begin
                        w_cnt_nxt       = r_cnt + CNT_W'(1);
                        w_ser_valid_nxt = 1'b1;
                        w_word_done_nxt = (r_cnt == PRE_LAST);
                        if (MSB_FIRST) begin
                            w_ser_out_nxt = r_shift[DATA_W-1];
                            w_shift_nxt   = r_shift << 1;
                        end else begin
                            w_ser_out_nxt = r_shift[0];
                            w_shift_nxt   = r_shift >> 1;
                        end
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    assign ser_out   = r_ser_out;
    assign ser_valid = r_ser_valid;
    assign word_done = r_word_done;
    assign busy      = r_ser_valid;

endmodule

// File: tb/tb_bit_serializer.sv
// Scoreboard bench for bit_serializer: stimulus pushes hand-written bit sequences,
// per-instance monitors pop and compare whenever the serial line is valid.
module tb_bit_serializer;

    typedef struct packed {
        logic b;
        logic last;
    } exp_t;

    logic clk;
    logic reset;

    logic       a_valid, a_ready, a_ser_out, a_ser_valid, a_word_done, a_busy;
    logic [7:0] a_data;
    logic       b_valid, b_ready, b_ser_out, b_ser_valid, b_word_done, b_busy;
    logic [7:0] b_data;
    logic       c_valid, c_ready, c_ser_out, c_ser_valid, c_word_done, c_busy;
    logic [7:0] c_data;

    exp_t qa[$];
    exp_t qb[$];
    int   n_pass  = 0;
    int   n_total = 0;
    int   last_wait;
    int   nb      = 0;
    int   det_idx = 0;
    logic [3:0] hist = '0;

    bit_serializer #(.DATA_W(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) u_a (
        .clk(clk), .reset(reset), .s_valid(a_valid), .s_data(a_data), .s_ready(a_ready),
        .ser_out(a_ser_out), .ser_valid(a_ser_valid), .word_done(a_word_done), .busy(a_busy)
    );

    bit_serializer #(.DATA_W(8), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0)) u_b (
        .clk(clk), .reset(reset), .s_valid(b_valid), .s_data(b_data), .s_ready(b_ready),
        .ser_out(b_ser_out), .ser_valid(b_ser_valid), .word_done(b_word_done), .busy(b_busy)
    );

    bit_serializer #(.DATA_W(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b1)) u_c (
        .clk(clk), .reset(reset), .s_valid(c_valid), .s_data(c_data), .s_ready(c_ready),
        .ser_out(c_ser_out), .ser_valid(c_ser_valid), .word_done(c_word_done), .busy(c_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic fail_now(input string name);
        n_total++;
        $display("FAIL %s", name);
    endtask

    // Offer a word to instance sel; exp_seq lists the wire bits first-to-last from its MSB.
    task automatic send(input int sel, input logic [7:0] d, input logic [7:0] exp_seq,
                        input bit hold);
        int   w;
        exp_t e;
        w = 0;
        if (sel == 0) begin a_valid = 1'b1; a_data = d; end
        else          begin b_valid = 1'b1; b_data = d; end
        while (((sel == 0) ? a_ready : b_ready) !== 1'b1 && w < 50) begin
            @(posedge clk); #1;
            w++;
        end
        if (w >= 50) fail_now("send_ready_timeout");
        last_wait = w;
        @(posedge clk); #1;
        for (int i = 0; i < 8; i++) begin
            e.b    = exp_seq[7-i];
            e.last = (i == 7);
            if (sel == 0) qa.push_back(e);
            else          qb.push_back(e);
        end
        if (!hold) begin
            if (sel == 0) a_valid = 1'b0;
            else          b_valid = 1'b0;
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (a_ser_valid === 1'b1) begin
            if (qa.size() == 0) begin
                fail_now("a_unexpected_bit");
            end else begin
                e = qa.pop_front();
                chk("a_ser_out", 32'(a_ser_out), 32'(e.b));
                chk("a_word_done", 32'(a_word_done), 32'(e.last));
            end
        end else begin
            chk("a_idle_level", {30'd0, a_ser_out, a_word_done}, 32'd0);
            if (qa.size() != 0 && !reset) fail_now("a_gap_in_stream");
        end
        chk("a_busy", 32'(a_busy), 32'(a_ser_valid));
    end

    always @(negedge clk) begin
        exp_t e;
        if (b_ser_valid === 1'b1) begin
            if (qb.size() == 0) begin
                fail_now("b_unexpected_bit");
            end else begin
                e = qb.pop_front();
                chk("b_ser_out", 32'(b_ser_out), 32'(e.b));
                chk("b_word_done", 32'(b_word_done), 32'(e.last));
                nb++;
                hist = {hist[2:0], b_ser_out};
                if (hist == 4'b1011 && det_idx == 0) det_idx = nb;
            end
        end else begin
            chk("b_idle_level", {30'd0, b_ser_out, b_word_done}, 32'd0);
        end
    end

    initial begin
        reset = 1'b1;
        a_valid = 1'b0; a_data = '0;
        b_valid = 1'b0; b_data = '0;
        c_valid = 1'b0; c_data = '0;
        cycles(3);
        chk("rst_a_outs", {28'd0, a_ser_out, a_ser_valid, a_word_done, a_busy}, 32'd0);
        chk("rst_c_ser_out", 32'(c_ser_out), 32'd1);
        reset = 1'b0;
        chk("rst_a_ready", 32'(a_ready), 32'd1);

        // Idle for 20 cycles: both idle levels, ready held high.
        for (int i = 0; i < 20; i++) begin
            cycles(1);
            chk("idle_a_ready", 32'(a_ready), 32'd1);
            chk("idle_c_line", {29'd0, c_ser_out, c_ser_valid, c_ready}, 32'b101);
        end

        send(0, 8'hB0, 8'b10110000, 1'b0);
        chk("b0_ready_wait", 32'(last_wait), 32'd0);
        cycles(12);

        // Back-to-back: second word waits exactly 7 cycles for ready.
        send(0, 8'hA5, 8'b10100101, 1'b1);
        send(0, 8'h3C, 8'b00111100, 1'b0);
        chk("b2b_ready_wait", 32'(last_wait), 32'd7);
        for (int i = 0; i < 7; i++) begin
            chk("b2b_ready_low", 32'(a_ready), 32'd0);
            cycles(1);
        end
        chk("b2b_ready_last", 32'(a_ready), 32'd1);
        cycles(4);

        send(1, 8'h0D, 8'b10110000, 1'b0);
        cycles(12);

        // Input word churns while the shifter is busy.
        send(0, 8'hC3, 8'b11000011, 1'b0);
        for (int i = 0; i < 5; i++) begin
            a_data = 8'($urandom);
            cycles(1);
        end
        cycles(6);

        // Reset after three bits of 8'hFF: line drops at once, remainder discarded.
        send(0, 8'hFF, 8'b11111111, 1'b0);
        cycles(2);
        @(negedge clk); #1;
        chk("mid_rst_pending", 32'(qa.size()), 32'd5);
        reset = 1'b1;
        #1;
        chk("mid_rst_outs", {28'd0, a_ser_out, a_ser_valid, a_word_done, a_busy}, 32'd0);
        qa.delete();
        cycles(2);
        reset = 1'b0;
        chk("post_rst_ready", 32'(a_ready), 32'd1);
        cycles(15);

        chk("qa_drained", 32'(qa.size()), 32'd0);
        chk("qb_drained", 32'(qb.size()), 32'd0);
        chk("detect_1011_bit", 32'(det_idx), 32'd4);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
